// File: rtl/demux_rr_driver.sv
// demux_rr_driver: accepts a serial bit stream over valid/ready and steers
// each accepted bit to the next enabled demux channel in round-robin order.
// Each bit is held on sel/dmx_in for DWELL cycles, then at least one idle cycle follows.
module demux_rr_driver #(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    input  logic       din_valid,
    output logic       din_ready,
    input  logic [3:0] ch_mask,
    output logic [1:0] sel,
    output logic       dmx_in,
    output logic       busy,
    output logic [7:0] tx_count
);

    typedef enum logic {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL - 1);

    state_t           state;
    logic [1:0]       ptr;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       chosen;
    logic             accept;

    // Ready only while idle and at least one channel is enabled
    assign din_ready = (state == IDLE) && (ch_mask != 4'b0000);
    assign accept    = din_valid && din_ready;

    // First enabled channel scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4); the
    // scan runs backwards so the nearest enabled channel is written last.
    always_comb begin
        logic [1:0] idx;
        idx    = 2'b00;
        chosen = ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (ch_mask[idx]) begin
                chosen = idx;
            end
        end
    end

    // Control FSM with registered demux drive outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sel      <= 2'b00;
            dmx_in   <= 1'b0;
            busy     <= 1'b0;
            tx_count <= 8'd0;
            ptr      <= 2'b00;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sel      <= chosen;
                        dmx_in   <= din;
                        busy     <= 1'b1;
                        cnt      <= CNT_LOAD;
                        ptr      <= chosen + 2'd1;
                        tx_count <= tx_count + 8'd1;
                        state    <= DRIVE;
                    end else begin
                        // sel keeps its last value; demux outputs all read 0
                        dmx_in <= 1'b0;
                        busy   <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        dmx_in <= 1'b0;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_demux_rr_driver.sv
// Testbench for demux_rr_driver (DWELL=4): table-driven per-cycle vectors
// followed by a hand-written 256-bit run through the tx_count wrap.
module tb_demux_rr_driver;

    logic       clk;
    logic       rst;
    logic       din;
    logic       din_valid;
    logic       din_ready;
    logic [3:0] ch_mask;
    logic [1:0] sel;
    logic       dmx_in;
    logic       busy;
    logic [7:0] tx_count;

    demux_rr_driver #(.DWELL(4), .CNT_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .din_valid(din_valid),
        .din_ready(din_ready),
        .ch_mask  (ch_mask),
        .sel      (sel),
        .dmx_in   (dmx_in),
        .busy     (busy),
        .tx_count (tx_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock cycle: inputs, din_ready expected before the edge,
    // registered outputs expected just after the edge.
    typedef struct {
        logic       rst;
        logic       din;
        logic       vld;
        logic [3:0] mask;
        logic       chk_rdy;
        logic       rdy;
        logic [1:0] sel;
        logic       dmx;
        logic       busy;
        logic [7:0] tx;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic void push(logic r, logic d, logic v, logic [3:0] m, logic cr, logic rd,
                                 logic [1:0] s, logic dm, logic b, logic [7:0] t);
        vec_t x;
        x.rst = r; x.din = d; x.vld = v; x.mask = m; x.chk_rdy = cr; x.rdy = rd;
        x.sel = s; x.dmx = dm; x.busy = b; x.tx = t;
        vecs.push_back(x);
    endfunction

    // One accepted bit: accept edge, three more DRIVE edges, then the edge back to IDLE.
    // din_valid stays high through DRIVE to show it is ignored.
    function automatic void bit_seq(logic d, logic [3:0] m_acc, logic [3:0] m_drv,
                                    logic [1:0] s, logic [7:0] t);
        push(1'b0, d, 1'b1, m_acc, 1'b1, 1'b1, s, d, 1'b1, t);
        for (int i = 0; i < 3; i++) push(1'b0, ~d, 1'b1, m_drv, 1'b1, 1'b0, s, d, 1'b1, t);
        push(1'b0, ~d, 1'b1, m_drv, 1'b1, 1'b0, s, 1'b0, 1'b0, t);
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // busy==0 must imply dmx_in==0 at every sample point
    always @(negedge clk) begin
        if (!rst && busy === 1'b0 && dmx_in !== 1'b0) begin
            n_err++;
            $display("FAIL invariant: dmx_in=%b while busy=0 at %0t", dmx_in, $time);
        end
    end

    initial begin
        logic [7:0] exp_tx;
        int         bits;

        rst = 1'b1; din = 1'b0; din_valid = 1'b0; ch_mask = 4'b1111;

        // Reset for 2 cycles
        push(1'b1, 1'b0, 1'b0, 4'b1111, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0);
        push(1'b1, 1'b0, 1'b0, 4'b1111, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 8'd0);
        // Four back-to-back bits, all channels enabled
        bit_seq(1'b1, 4'b1111, 4'b1111, 2'd0, 8'd1);
        bit_seq(1'b1, 4'b1111, 4'b1111, 2'd1, 8'd2);
        bit_seq(1'b1, 4'b1111, 4'b1111, 2'd2, 8'd3);
        bit_seq(1'b1, 4'b1111, 4'b1111, 2'd3, 8'd4);
        // Mask 1010: only channels 1 and 3
        bit_seq(1'b1, 4'b1010, 4'b1010, 2'd1, 8'd5);
        bit_seq(1'b1, 4'b1010, 4'b1010, 2'd3, 8'd6);
        bit_seq(1'b1, 4'b1010, 4'b1010, 2'd1, 8'd7);
        // Empty mask: back-pressure for 10 cycles, din toggling and ignored
        for (int i = 0; i < 10; i++)
            push(1'b0, i[0], 1'b1, 4'b0000, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 8'd7);
        bit_seq(1'b1, 4'b0100, 4'b0100, 2'd2, 8'd8);
        // Bit on ch2, reset asserted in its 2nd DRIVE cycle
        push(1'b0, 1'b1, 1'b1, 4'b0100, 1'b1, 1'b1, 2'd2, 1'b1, 1'b1, 8'd9);
        push(1'b0, 1'b0, 1'b1, 4'b0100, 1'b1, 1'b0, 2'd2, 1'b1, 1'b1, 8'd9);
        push(1'b1, 1'b0, 1'b1, 4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0);
        bit_seq(1'b1, 4'b1111, 4'b1111, 2'd0, 8'd1);
        // Mask changes to 0001 mid-DRIVE: bit stays on ch1, next goes to ch0 (din=0)
        bit_seq(1'b1, 4'b1111, 4'b0001, 2'd1, 8'd2);
        bit_seq(1'b0, 4'b0001, 4'b0001, 2'd0, 8'd3);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst; din = vecs[i].din; din_valid = vecs[i].vld; ch_mask = vecs[i].mask;
            #1;
            if (vecs[i].chk_rdy) chk($sformatf("v%0d din_ready", i), 8'(din_ready), 8'(vecs[i].rdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d sel", i), 8'(sel), 8'(vecs[i].sel));
            chk($sformatf("v%0d dmx_in", i), 8'(dmx_in), 8'(vecs[i].dmx));
            chk($sformatf("v%0d busy", i), 8'(busy), 8'(vecs[i].busy));
            chk($sformatf("v%0d tx_count", i), tx_count, vecs[i].tx);
        end

        // 256 more bits on ch0: tx_count passes 255->0 and lands back on 3
        exp_tx = 8'd3;
        bits   = 0;
        for (int c = 0; c < 3000 && bits < 256; c++) begin
            @(negedge clk);
            rst = 1'b0; din = bits[0]; din_valid = 1'b1; ch_mask = 4'b0001;
            #1;
            if (din_ready) begin
                @(posedge clk);
                #1;
                exp_tx = exp_tx + 8'd1;
                chk($sformatf("wrap%0d tx_count", bits), tx_count, exp_tx);
                chk($sformatf("wrap%0d sel", bits), 8'(sel), 8'd0);
                chk($sformatf("wrap%0d dmx_in", bits), 8'(dmx_in), 8'(bits[0]));
                bits++;
            end
        end
        chk("wrap bits accepted", 8'(bits == 256), 8'd1);
        chk("wrap final tx_count", tx_count, 8'd3);

        din_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("end busy", 8'(busy), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/demux_rr_driver.md
Name: demux_rr_driver

Overview:
Upstream driver for the 1-to-4 demultiplexer stage. Accepts a serial bit stream over a valid/ready handshake. Steers each accepted bit to the next enabled output channel in round-robin order by driving the demux select and data inputs, holding each bit stable for a programmable dwell time. Its sel/dmx_in outputs connect directly to the demux in/sel inputs; the demux out[3:0] carries the distributed bits.

Parameters:
DWELL, 4, cycles each accepted bit is presented to the demux; legal range 1..255
CNT_W, 8, width of the dwell counter; must hold DWELL-1

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
din  input  1  serial data bit to distribute
din_valid  input  1  din is valid this cycle
din_ready  output  1  block can accept din this cycle (combinational)
ch_mask  input  4  channel enable mask, bit i enables demux channel i
sel  output  2  demux select, drives demux sel
dmx_in  output  1  demux data, drives demux in
busy  output  1  a bit is currently being presented
tx_count  output  8  total bits accepted since reset, wraps 255->0

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset (rst=1 at a rising edge): state=IDLE, sel=2'b00, dmx_in=0, busy=0, tx_count=0, rr pointer ptr=0, dwell counter=0. Reset takes priority over all other events.
- All outputs except din_ready are registered.
- States: IDLE, DRIVE.
- din_ready = (state==IDLE) && (ch_mask!=4'b0000). It never depends on din_valid.
- Accept: a transfer occurs on an edge where din_valid && din_ready.
- IDLE on accept:
  - chosen = first i in order ptr, ptr+1, ptr+2, ptr+3 (mod 4) with ch_mask[i]=1.
  - sel<=chosen, dmx_in<=din, busy<=1, cnt<=DWELL-1, ptr<=chosen+1 (mod 4, 3 wraps to 0), tx_count<=tx_count+1 (mod 256).
  - Next state: DRIVE.
- IDLE without accept: hold sel at its last value; dmx_in=0, busy=0, so all demux outputs are 0.
- DRIVE: sel and dmx_in are held.
  - If cnt!=0: cnt<=cnt-1.
  - If cnt==0: dmx_in<=0, busy<=0, next state IDLE.
  - Each bit is therefore presented for exactly DWELL cycles, followed by at least one IDLE cycle. Peak throughput is 1 bit per DWELL+1 cycles.
- ch_mask is sampled only at the accept edge. Changes during DRIVE do not affect the bit in flight.
- ch_mask==0: din_ready=0, no transfer occurs, and state holds. Data offered during this time is back-pressured, not dropped.
- A single enabled channel is selected on every transfer. ptr still advances past it.
- din_valid=1 during DRIVE: ignored (din_ready=0). The upstream source holds its data.
- Reset during DRIVE: the in-flight bit is abandoned. On the next edge all outputs return to reset values, and the following accepted bit goes to the lowest enabled channel starting from ch0.
- The value of din is ignored when no transfer occurs.
- Invariant: busy==0 implies dmx_in==0.

Test Plan:
1. rst=1 for 2 cycles, ch_mask=4'b1111 -> sel=00, dmx_in=0, busy=0, tx_count=0, din_ready=1.
2. DWELL=4, ch_mask=1111, four back-to-back din=1 offers -> sel=00,01,10,11, each held 4 cycles with dmx_in=1; demux out=0001,0010,0100,1000; 1 idle cycle between bits; tx_count=4.
3. ch_mask=1010, three din=1 bits -> sel=01,11,01. Channels 0 and 2 are never selected.
4. ch_mask=0000, din_valid=1 for 10 cycles -> din_ready=0, busy=0, tx_count unchanged. Then ch_mask=0100 -> the bit is accepted on the next edge and sel=10.
5. Assert rst in the 2nd DRIVE cycle of a bit on ch2 -> next edge busy=0, dmx_in=0, sel=00. The next accepted bit with mask=1111 goes to ch0.
6. Change ch_mask 1111->0001 mid-DRIVE -> the current bit finishes on its original sel; the next bit goes to sel=00. Send 256 bits -> tx_count wraps to 0.
